dual_rail_receiver: RTL and testbench
=====================================

// Module: dual_rail_receiver
// PURPOSE
//  Receiving end of the Sender's dual-rail, return-to-zero serial link (Bit0/Bit1 wires + ack).
//  Decodes one bit per four-phase handshake and assembles WIDTH bits, MSB first, into a word.
//  Issues a one-cycle comp pulse per completed word and flags protocol violations and stalled frames.
//  Sits on the far side of the link from Sender and feeds decoded words to downstream control logic.
// PARAMETERS
//  WIDTH    8     bits per frame (>=2)
//  TIMEOUT  1024  max clk cycles waiting for the next bit mid-frame before abort; 0 disables
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-low reset
//  Bit0_In   in   1      rail "0" from Sender (asynchronous to clk)
//  Bit1_In   in   1      rail "1" from Sender (asynchronous to clk)
//  ack       out  1      handshake acknowledge back to Sender
//  data_out  out  WIDTH  last completed word; held until next word completes
//  comp      out  1      one-cycle pulse: data_out updated this cycle
//  busy      out  1      high while a frame is partially received (bit_cnt != 0)
//  err       out  1      one-cycle pulse on protocol violation or timeout
// BEHAVIOUR
//  - Reset (reset=0): ack=0, data_out=0, comp=0, busy=0, err=0, shift reg=0, bit_cnt=0,
//    timer=0, synchronisers=0, state=WAIT_DATA. Reset mid-frame discards the partial word.
//  - Bit0_In/Bit1_In each pass through a 2-FF synchroniser; all logic below uses synced b0/b1.
//  - States: WAIT_DATA, WAIT_NULL, ERROR.
//  - WAIT_DATA: b0^b1 -> shift in (shreg <= {shreg[WIDTH-2:0], b1}), ack<=1, -> WAIT_NULL.
//    b0&b1 -> ERROR. Both low -> stay.
//  - WAIT_NULL: both low -> ack<=0, bit_cnt++; if bit_cnt reaches WIDTH then data_out<=shreg,
//    comp=1 for that cycle, bit_cnt<=0; -> WAIT_DATA. b0&b1 -> ERROR. One rail high -> stay (ack held).
//  - ERROR: err=1 on entry cycle only; ack<=0, bit_cnt<=0, shreg<=0, data_out unchanged;
//    stay until both rails low, then -> WAIT_DATA.
//  - Latency: input edge -> ack rise = 3 clk (2 sync + 1 reg); rails null -> ack fall = 3 clk;
//    comp asserts in the same cycle ack falls for the final bit.
//  - Timeout: timer counts cycles in WAIT_DATA with bit_cnt!=0; clears on any bit accepted.
//    When timer == TIMEOUT (TIMEOUT>0): err pulse, bit_cnt<=0, shreg<=0, stay WAIT_DATA.
//    Not active between frames (bit_cnt==0) or in WAIT_NULL (Sender owns rails there).
//  - b0&b1 seen in the same cycle as a timeout: protocol error wins (-> ERROR, single err pulse).
//  - A rail changing from Bit0 to Bit1 without passing through null is not visible as a new bit:
//    stays in WAIT_NULL until both low (bit value already latched).
//  - busy = (bit_cnt != 0); goes low the cycle comp pulses.
//  - No backpressure: consecutive words overwrite data_out; consumer must sample on comp.
// TESTING
//  1 Reset then send 8'hA5 MSB first via full 4-phase handshakes -> exactly 8 ack pulses, one comp
//    pulse, data_out=8'hA5, busy low after comp, err never set.
//  2 Back-to-back 8'h00 then 8'hFF -> two comp pulses, data_out 8'h00 then 8'hFF; ack rise/fall
//    each 3 clk after the corresponding rail change.
//  3 Send 3 bits of a frame, then drive Bit0_In=Bit1_In=1 -> one err pulse, ack=0, busy=0; drop rails,
//    send 8'h3C -> comp with data_out=8'h3C (stale bits not included).
//  4 TIMEOUT=16: send 2 bits then leave rails null 20 cycles -> err pulse at cycle 16 of idle,
//    busy=0; following full 8'h81 frame -> data_out=8'h81.
//  5 Assert reset low mid-frame while ack=1 -> ack, busy, comp, err, data_out all 0 immediately
//    (asynchronously); after release a clean 8'h5A frame decodes correctly.
//  6 Idle with rails null for 5000 cycles (TIMEOUT=1024) -> no err, no comp, ack stays 0.

Source files
------------

// File: rtl/dual_rail_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dual_rail_receiver
// Description : Four-phase dual-rail RZ link receiver; assembles WIDTH-bit
//               MSB-first words, flags protocol violations and stalled frames.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_rail_receiver #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Bit0_In,
    input  logic             Bit1_In,
    output logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             comp,
    output logic             busy,
    output logic             err
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam int c_TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_TMR_W-1:0] c_TIMEOUT  = c_TMR_W'(TIMEOUT);
    localparam bit                 c_TMO_EN   = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        WAIT_DATA = 2'd0,
        WAIT_NULL = 2'd1,
        ERROR     = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_b0_meta, r_b0_sync;
    logic               r_b1_meta, r_b1_sync;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_data;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_ack;
    logic               r_comp;
    logic               r_err;

    logic w_both;
    logic w_one;
    logic w_null;

    assign w_both = r_b0_sync & r_b1_sync;
    assign w_one  = r_b0_sync ^ r_b1_sync;
    assign w_null = ~(r_b0_sync | r_b1_sync);

    // Rails come from another clock domain: two flops each before any use.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_b0_meta <= 1'b0;
            r_b0_sync <= 1'b0;
            r_b1_meta <= 1'b0;
            r_b1_sync <= 1'b0;
        end else begin
            r_b0_meta <= Bit0_In;
            r_b0_sync <= r_b0_meta;
            r_b1_meta <= Bit1_In;
            r_b1_sync <= r_b1_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= WAIT_DATA;
            r_shreg   <= '0;
            r_data    <= '0;
            r_bit_cnt <= '0;
            r_timer   <= '0;
            r_ack     <= 1'b0;
            r_comp    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_comp <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                WAIT_DATA: begin
                    // A protocol violation outranks a timeout seen in the same cycle.
                    if (w_both) begin
                        r_state   <= ERROR;
                        r_err     <= 1'b1;
                        r_bit_cnt <= '0;
                        r_shreg   <= '0;
                        r_timer   <= '0;
                    end else if (w_one) begin
                        r_shreg <= {r_shreg[WIDTH-2:0], r_b1_sync};
                        r_ack   <= 1'b1;
                        r_timer <= '0;
                        r_state <= WAIT_NULL;
                    end else if (c_TMO_EN && (r_bit_cnt != '0)) begin
                        if (r_timer == c_TIMEOUT) begin
                            r_err     <= 1'b1;
                            r_bit_cnt <= '0;
                            r_shreg   <= '0;
                            r_timer   <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                WAIT_NULL: begin
                    if (w_both) begin
                        r_state   <= ERROR;
                        r_err     <= 1'b1;
                        r_ack     <= 1'b0;
                        r_bit_cnt <= '0;
                        r_shreg   <= '0;
                        r_timer   <= '0;
                    end else if (w_null) begin
                        r_ack   <= 1'b0;
                        r_state <= WAIT_DATA;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_data    <= r_shreg;
                            r_comp    <= 1'b1;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ERROR: begin
                    r_ack <= 1'b0;
                    if (w_null) begin
                        r_state <= WAIT_DATA;
                    end
                end
                default: begin
                    r_state <= WAIT_DATA;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign data_out = r_data;
    assign comp     = r_comp;
    assign err      = r_err;
    assign busy     = (r_bit_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_dual_rail_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dual_rail_receiver
// Description : Self-checking bench for dual_rail_receiver (TIMEOUT 1024 and 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_rail_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit0 = 1'b0;
    logic       bit1 = 1'b0;
    logic       ack_a, comp_a, busy_a, err_a;
    logic       ack_b, comp_b, busy_b, err_b;
    logic [7:0] data_a, data_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dual_rail_receiver #(.WIDTH(8), .TIMEOUT(1024)) dut_a (
        .clk(clk), .reset(reset), .Bit0_In(bit0), .Bit1_In(bit1),
        .ack(ack_a), .data_out(data_a), .comp(comp_a), .busy(busy_a), .err(err_a)
    );

    dual_rail_receiver #(.WIDTH(8), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .Bit0_In(bit0), .Bit1_In(bit1),
        .ack(ack_b), .data_out(data_b), .comp(comp_b), .busy(busy_b), .err(err_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level view of the link: a held token, a bit tally and a word value.
    typedef struct {
        bit ack;
        bit fault;
        int nbits;
        int word;
        int out;
        int idle;
        bit comp;
        bit err;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.ack = 0; m.fault = 0; m.nbits = 0; m.word = 0;
        m.out = 0; m.idle = 0; m.comp = 0; m.err = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m_in, bit d0, bit d1, int tmo);
        mdl_t m = m_in;
        m.comp = 0;
        m.err  = 0;
        if (m.fault) begin
            if (!d0 && !d1) m.fault = 0;
        end else if (d0 && d1) begin
            m.fault = 1; m.ack = 0; m.nbits = 0; m.word = 0; m.idle = 0; m.err = 1;
        end else if (!m.ack) begin
            if (d0 != d1) begin
                m.word = (m.word * 2 + int'(d1)) % 256;
                m.ack  = 1;
                m.idle = 0;
            end else if (m.nbits > 0 && tmo > 0) begin
                if (m.idle == tmo) begin
                    m.err = 1; m.nbits = 0; m.word = 0; m.idle = 0;
                end else begin
                    m.idle++;
                end
            end
        end else if (!d0 && !d1) begin
            m.ack = 0;
            m.nbits++;
            if (m.nbits == 8) begin
                m.out = m.word; m.comp = 1; m.nbits = 0;
            end
        end
        return m;
    endfunction

    mdl_t ma, mb;
    bit   dl0 [2];
    bit   dl1 [2];

    // The DUT acts on rail values sampled two edges earlier.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma = mdl_reset();
            mb = mdl_reset();
            dl0[0] = 0; dl0[1] = 0; dl1[0] = 0; dl1[1] = 0;
        end else begin
            ma = step(ma, dl0[1], dl1[1], 1024);
            mb = step(mb, dl0[1], dl1[1], 16);
            dl0[1] = dl0[0]; dl1[1] = dl1[0];
            dl0[0] = bit0;   dl1[0] = bit1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("a_ack",  int'(ack_a),  int'(ma.ack));
            chk("a_comp", int'(comp_a), int'(ma.comp));
            chk("a_err",  int'(err_a),  int'(ma.err));
            chk("a_busy", int'(busy_a), int'(ma.nbits != 0));
            chk("a_data", int'(data_a), ma.out);
            chk("b_ack",  int'(ack_b),  int'(mb.ack));
            chk("b_comp", int'(comp_b), int'(mb.comp));
            chk("b_err",  int'(err_b),  int'(mb.err));
            chk("b_busy", int'(busy_b), int'(mb.nbits != 0));
            chk("b_data", int'(data_b), mb.out);
        end
    end

    int cyc = 0;
    int ack_rise_a = 0, comp_cnt_a = 0, err_cnt_a = 0, comp_cnt_b = 0, err_cnt_b = 0;
    int fall_cyc_b = 0, err_cyc_b = 0;
    bit prev_ack_a = 0, prev_ack_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack_a && !prev_ack_a) ack_rise_a++;
        if (comp_a) comp_cnt_a++;
        if (err_a)  err_cnt_a++;
        if (comp_b) comp_cnt_b++;
        if (err_b) begin
            err_cnt_b++;
            err_cyc_b = cyc;
        end
        if (!ack_b && prev_ack_b) fall_cyc_b = cyc;
        prev_ack_a = ack_a;
        prev_ack_b = ack_b;
    end

    task automatic send_bit(input logic b, input bit lat);
        @(negedge clk);
        bit0 = ~b;
        bit1 = b;
        repeat (2) @(negedge clk);
        if (lat) chk("lat_rise_early", int'(ack_a), 0);
        @(negedge clk);
        if (lat) chk("lat_rise_3clk", int'(ack_a), 1);
        repeat (2) @(negedge clk);
        bit0 = 1'b0;
        bit1 = 1'b0;
        repeat (2) @(negedge clk);
        if (lat) chk("lat_fall_early", int'(ack_a), 1);
        @(negedge clk);
        if (lat) chk("lat_fall_3clk", int'(ack_a), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input bit lat);
        for (int i = 7; i >= 0; i--) send_bit(w[i], lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    int s_rise, s_comp, s_err, s_comp_b, s_err_b;

    task automatic snap();
        s_rise = ack_rise_a; s_comp = comp_cnt_a; s_err = err_cnt_a;
        s_comp_b = comp_cnt_b; s_err_b = err_cnt_b;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack",  int'(ack_a),  0);
        chk("rst_data", int'(data_a), 0);
        chk("rst_comp", int'(comp_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_err",  int'(err_a),  0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single A5 frame
        snap();
        send_word(8'hA5, 1'b0);
        chk("t1_ack_pulses", ack_rise_a - s_rise, 8);
        chk("t1_comp_pulses", comp_cnt_a - s_comp, 1);
        chk("t1_data", int'(data_a), 'hA5);
        chk("t1_busy", int'(busy_a), 0);
        chk("t1_err", err_cnt_a - s_err, 0);

        // 2: back-to-back 00 then FF with latency checks
        snap();
        send_word(8'h00, 1'b1);
        chk("t2_data00", int'(data_a), 'h00);
        chk("t2_comp1", comp_cnt_a - s_comp, 1);
        send_word(8'hFF, 1'b1);
        chk("t2_dataFF", int'(data_a), 'hFF);
        chk("t2_comp2", comp_cnt_a - s_comp, 2);

        // 3: protocol violation mid-frame, then clean 3C
        snap();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clk);
        bit0 = 1'b1;
        bit1 = 1'b1;
        repeat (6) @(negedge clk);
        chk("t3_err_pulse", err_cnt_a - s_err, 1);
        chk("t3_ack", int'(ack_a), 0);
        chk("t3_busy", int'(busy_a), 0);
        bit0 = 1'b0;
        bit1 = 1'b0;
        repeat (6) @(negedge clk);
        send_word(8'h3C, 1'b0);
        chk("t3_data", int'(data_a), 'h3C);
        chk("t3_data_b", int'(data_b), 'h3C);

        // 4: stall mid-frame; only the TIMEOUT=16 instance aborts
        snap();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t4_err_b", err_cnt_b - s_err_b, 1);
        chk("t4_err_delay", err_cyc_b - fall_cyc_b, 17);
        chk("t4_busy_b", int'(busy_b), 0);
        chk("t4_err_a", err_cnt_a - s_err, 0);
        chk("t4_busy_a", int'(busy_a), 1);
        send_word(8'h81, 1'b0);
        chk("t4_data_b", int'(data_b), 'h81);
        chk("t4_data_a_stale", int'(data_a), 'hE0);

        // 5: asynchronous reset while ack is high
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clk);
        bit1 = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_ack_before", int'(ack_a), 1);
        #3;
        reset = 1'b0;
        #1;
        chk("t5_ack",  int'(ack_a),  0);
        chk("t5_busy", int'(busy_a), 0);
        chk("t5_comp", int'(comp_a), 0);
        chk("t5_err",  int'(err_a),  0);
        chk("t5_data", int'(data_a), 0);
        chk("t5_data_b", int'(data_b), 0);
        bit1 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send_word(8'h5A, 1'b0);
        chk("t5_data_5A", int'(data_a), 'h5A);
        chk("t5_data_5A_b", int'(data_b), 'h5A);

        // 6: long idle between frames
        snap();
        repeat (5000) @(negedge clk);
        chk("t6_err", err_cnt_a - s_err, 0);
        chk("t6_comp", comp_cnt_a - s_comp, 0);
        chk("t6_ack_rises", ack_rise_a - s_rise, 0);
        chk("t6_ack", int'(ack_a), 0);
        chk("t6_err_b", err_cnt_b - s_err_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
